// File: rtl/periph_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the UART transmit peripheral.
package periph_pkg;

  localparam logic [5:0] REG_TXDATA = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic full,
                                              input logic empty,
                                              input logic busy);
    logic [31:0] w;
    w                 = '0;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_BUSY_BIT]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: wrapping pointers plus an occupancy counter one bit wider
// than the pointers, so full and empty are unambiguous.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Head is read combinationally so the transmitter can load it in the pop cycle.
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, a byte FIFO and an
// 8N1 serialiser with a registered, glitch-free line output.
module uart_tx_periph
  import periph_pkg::*;
#(
  parameter int CLK_DIV    = 208,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [5:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  tx_state_e   r_state;
  tx_state_e   w_state_next;
  logic [15:0] r_baud;
  logic [15:0] w_baud_next;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        r_tx;
  logic        w_tx_bit;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_fifo_rdata;
  logic        w_is_write;
  logic        w_is_txpush;
  logic        w_accept;
  logic [31:0] w_read_data;
  logic        w_unused;

  assign w_unused = ^mem_wdata[31:8];

  assign w_is_write  = |mem_wstrb;
  assign w_is_txpush = mem_valid && (mem_addr == REG_TXDATA) && mem_wstrb[0];
  // A push waits on the registered full flag; every other access completes at once.
  assign w_accept    = mem_valid && !r_ready && !(w_is_txpush && w_full);
  assign w_push      = w_accept && w_is_txpush;

  always_comb begin
    w_read_data = '0;
    if (mem_addr == REG_STATUS) begin
      w_read_data = status_word(w_full, w_empty, r_state != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !w_is_write) ? w_read_data : '0;
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_wdata (mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_tx_bit     = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next = ST_START;
          w_baud_next  = BAUD_RELOAD;
          w_shift_next = w_fifo_rdata;
          w_pop        = 1'b1;
        end
      end
      ST_START: begin
        w_tx_bit = 1'b0;
        if (r_baud == '0) begin
          w_state_next = ST_DATA;
          w_baud_next  = BAUD_RELOAD;
          w_bit_next   = '0;
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      ST_DATA: begin
        w_tx_bit = r_shift[0];
        if (r_baud == '0) begin
          w_baud_next  = BAUD_RELOAD;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_next = ST_STOP;
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      ST_STOP: begin
        w_tx_bit = 1'b1;
        if (r_baud == '0) begin
          // Chain straight into the next frame when a byte is already waiting.
          if (!w_empty) begin
            w_state_next = ST_START;
            w_baud_next  = BAUD_RELOAD;
            w_shift_next = w_fifo_rdata;
            w_pop        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_baud_next  = '0;
          end
        end else begin
          w_baud_next = r_baud - 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_bit;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign uart_tx   = r_tx;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: a frame-timeline model checked every cycle, plus
// directed bus transactions with hand-computed literal expectations.
module tb_uart_tx_periph;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [5:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  uart_tx_periph #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted byte becomes a frame on a timeline. A frame starts two
  // edges after its push, or right when the previous frame ends, whichever is later.
  int          f_push[$];
  int          f_start[$];
  logic [7:0]  f_data[$];
  int          next_free = 0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_rd = '0;
  bit          started = 0;
  logic        line_hist[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_line(input int t);
    logic r;
    int   idx;
    logic [9:0] fr;
    r = 1'b1;
    foreach (f_start[i]) begin
      if (t >= f_start[i] && t < f_start[i] + FRAME) begin
        idx = (t - f_start[i]) / DIV;
        fr  = {1'b1, f_data[i], 1'b0};
        r   = fr[idx];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin : model_cmp
    int   e;
    int   cnt;
    logic busy;
    logic full;
    logic empty;
    logic txpush;
    logic accept;
    int   st;
    if (started) begin
      chk("tx", 32'(uart_tx), 32'(exp_line(cyc)));
      chk("ready", 32'(mem_ready), 32'(m_rdy));
      chk("rdata", mem_rdata, m_rd);
    end
    line_hist[cyc] = uart_tx;
    e = cyc + 1;
    if (!nrst) begin
      started = 1;
      f_push.delete();
      f_start.delete();
      f_data.delete();
      next_free = 0;
      m_rdy = 1'b0;
      m_rd = '0;
    end else begin
      cnt = 0;
      busy = 1'b0;
      foreach (f_start[i]) begin
        if (f_push[i] < e && f_start[i] - 1 >= e) cnt++;
        if (e >= f_start[i] && e <= f_start[i] + FRAME - 1) busy = 1'b1;
      end
      full   = (cnt == DEPTH);
      empty  = (cnt == 0);
      txpush = mem_valid && (mem_addr == 6'd0) && mem_wstrb[0];
      accept = mem_valid && !m_rdy && !(txpush && full);
      m_rd   = '0;
      if (accept && mem_wstrb == 4'h0 && mem_addr == 6'd1)
        m_rd = {29'b0, busy, empty, full};
      m_rdy = accept;
      if (accept && txpush) begin
        st = (e + 2 > next_free) ? e + 2 : next_free;
        f_push.push_back(e);
        f_start.push_back(st);
        f_data.push_back(mem_wdata[7:0]);
        next_free = st + FRAME;
      end
    end
  end

  // Entered and left at #1 after a rising edge.
  task automatic bus(input logic [5:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int acc_edge, output int lat);
    bit got;
    got = 0;
    rd = '0;
    acc_edge = -1;
    lat = 0;
    mem_addr = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        got = 1;
        rd = mem_rdata;
        acc_edge = cyc;
      end
    end
    if (!got) begin
      n_checks++;
      n_bad++;
      $display("FAIL bus_timeout addr=%0d: got no ready want ready", a);
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic chk_pat(input string name, input int start, input logic [9:0] pat);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < DIV; j++)
        chk(name, 32'(line_hist[start + k * DIV + j]), 32'(pat[k]));
  endtask

  function automatic logic [7:0] decode(input int start);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = line_hist[start + DIV * (1 + i) + 1];
    return b;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    logic [31:0] rd;
    int ae, lat, p, p1, p2, lows, t0;
    int acc[1:10];
    int lt[1:10];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;

    // status and unmapped offsets
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_idle", rd, 32'h2);
    chk("read_latency", 32'(lat), 32'd2);
    bus(6'd5, 32'h0, 4'h0, rd, ae, lat);
    chk("read_off5", rd, 32'h0);
    bus(6'd0, 32'h0, 4'h0, rd, ae, lat);
    chk("read_txdata", rd, 32'h0);
    bus(6'd7, 32'hFFFF_FFFF, 4'hF, rd, ae, lat);
    chk("write_off7_latency", 32'(lat), 32'd2);
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_after_off7", rd, 32'h2);

    // non-byte strobe
    t0 = cyc;
    bus(6'd0, 32'h77, 4'b0010, rd, ae, lat);
    chk("strobe_latency", 32'(lat), 32'd2);
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_after_strobe", rd, 32'h2);
    wait_until(cyc + 20);
    lows = 0;
    for (int t = t0; t < cyc - 1; t++) if (line_hist[t] !== 1'b1) lows++;
    chk("line_quiet", 32'(lows), 32'd0);

    // single byte 0x55
    bus(6'd0, 32'h55, 4'h1, rd, p, lat);
    chk("push_latency", 32'(lat), 32'd2);
    wait_until(p + FRAME + 10);
    chk("pre_start_high", 32'(line_hist[p + 1]), 32'h1);
    chk_pat("frame_55", p + 2, 10'b1010101010);
    for (int t = p + 2 + FRAME; t < p + 6 + FRAME; t++)
      chk("idle_after_55", 32'(line_hist[t]), 32'h1);

    // back-to-back frames
    bus(6'd0, 32'hA5, 4'h1, rd, p1, lat);
    bus(6'd0, 32'h3C, 4'h1, rd, p2, lat);
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_busy", rd, 32'h4);
    wait_until(p1 + 2 * FRAME + 10);
    chk_pat("frame_A5", p1 + 2, 10'b1101001010);
    chk_pat("frame_3C", p1 + 2 + FRAME, 10'b1001111000);
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_after_b2b", rd, 32'h2);

    // FIFO full stall
    for (int k = 1; k <= 10; k++) begin
      bus(6'd0, 32'(8'h10 + k), 4'h1, rd, acc[k], lt[k]);
    end
    for (int k = 1; k <= 9; k++) chk("fill_latency", 32'(lt[k]), 32'd2);
    chk("stall_release", 32'(acc[10] - acc[1]), 32'(FRAME + 2));
    wait_until(acc[1] + 2 + 10 * FRAME + 10);
    for (int k = 1; k <= 10; k++)
      chk("stall_order", 32'(decode(acc[1] + 2 + FRAME * (k - 1))), 32'(8'h10 + k));
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_after_stall", rd, 32'h2);

    // reset mid-frame, during DATA bit 3
    bus(6'd0, 32'hC3, 4'h1, rd, p, lat);
    bus(6'd0, 32'h99, 4'h1, rd, ae, lat);
    wait_until(p + 19);
    nrst = 1'b0;
    @(negedge clk);
    chk("data_bit3_low", 32'(uart_tx), 32'h0);
    @(negedge clk);
    chk("abort_line_high", 32'(uart_tx), 32'h1);
    @(posedge clk);
    #1 nrst = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus(6'd1, 32'h0, 4'h0, rd, ae, lat);
    chk("status_after_reset", rd, 32'h2);
    wait_until(cyc + 2 * FRAME);
    lows = 0;
    for (int t = t0; t < cyc - 1; t++) if (line_hist[t] !== 1'b1) lows++;
    chk("no_residual_frame", 32'(lows), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
